// File: rtl/timer60_setter.sv
// Four-button BCD preset entry for the 0-59 timer, with a one-cycle set_time strobe.
// Build option: define DEBOUNCE_EN to add a per-button stable-level debounce filter.
module timer60_setter #(
  parameter logic [3:0] UNIT_MAX   = 4'd9,
  parameter logic [3:0] DOZEN_MAX  = 4'd5,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_load,
  output logic [3:0] Init_unitvalue,
  output logic [3:0] Init_dozenvalue,
  output logic       set_time,
  output logic       editing,
  output logic       edit_digit
);

  typedef enum logic [1:0] {
    IDLE, EDIT_UNIT, EDIT_DOZEN, LOAD
  } state_e;

  logic [3:0] raw;
  logic [3:0] s1_q, s2_q;
  logic [3:0] lvl;
  logic [3:0] prev_q;
  logic [3:0] pulse_d, pulse_q;

  // bit order: load, mode, inc, dec
  assign raw = {btn_load, btn_mode, btn_inc, btn_dec};

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [3:0]         flt_d, flt_q;
  logic [3:0][CW-1:0] cnt_d, cnt_q;

  always_comb begin
    flt_d = flt_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] != flt_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          flt_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_q <= '0;
      cnt_q <= '0;
    end else begin
      flt_q <= flt_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = flt_q;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES != 0);
  assign lvl = s2_q;
`endif

  assign pulse_d = lvl & ~prev_q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      prev_q  <= lvl;
      pulse_q <= pulse_d;
    end
  end

  logic p_load, p_mode, p_inc, p_dec;
  assign {p_load, p_mode, p_inc, p_dec} = pulse_q;

  state_e     state_d, state_q;
  logic [3:0] unit_d, unit_q;
  logic [3:0] dozen_d, dozen_q;
  logic       set_d, set_q;
  logic       edit_d, edit_q;
  logic       dig_d, dig_q;

  logic [3:0] unit_inc, unit_dec;
  logic [3:0] dozen_inc, dozen_dec;
  logic       step;

  assign unit_inc  = (unit_q >= UNIT_MAX) ? 4'd0 : unit_q + 4'd1;
  assign unit_dec  = (unit_q == 4'd0) ? UNIT_MAX : unit_q - 4'd1;
  assign dozen_inc = (dozen_q >= DOZEN_MAX) ? 4'd0 : dozen_q + 4'd1;
  assign dozen_dec = (dozen_q == 4'd0) ? DOZEN_MAX : dozen_q - 4'd1;
  // inc and dec together cancel out
  assign step = p_inc ^ p_dec;

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    dozen_d = dozen_q;
    unique case (state_q)
      IDLE: begin
        if (p_load)      state_d = LOAD;
        else if (p_mode) state_d = EDIT_UNIT;
      end
      EDIT_UNIT: begin
        if (p_load)      state_d = LOAD;
        else if (p_mode) state_d = EDIT_DOZEN;
        else if (step)   unit_d  = p_inc ? unit_inc : unit_dec;
      end
      EDIT_DOZEN: begin
        if (p_load)      state_d = LOAD;
        else if (p_mode) state_d = IDLE;
        else if (step)   dozen_d = p_inc ? dozen_inc : dozen_dec;
      end
      LOAD: state_d = IDLE;
    endcase
    set_d  = (state_d == LOAD);
    edit_d = (state_d == EDIT_UNIT) || (state_d == EDIT_DOZEN);
    dig_d  = (state_d == EDIT_DOZEN);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      unit_q  <= '0;
      dozen_q <= '0;
      set_q   <= 1'b0;
      edit_q  <= 1'b0;
      dig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      dozen_q <= dozen_d;
      set_q   <= set_d;
      edit_q  <= edit_d;
      dig_q   <= dig_d;
    end
  end

  assign Init_unitvalue  = unit_q;
  assign Init_dozenvalue = dozen_q;
  assign set_time        = set_q;
  assign editing         = edit_q;
  assign edit_digit      = dig_q;

endmodule

// File: tb/tb_timer60_setter.sv
// Directed table-driven bench for timer60_setter (default build),
// plus hand sequences for latency, held buttons and mid-edit reset.
module tb_timer60_setter;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       btn_mode, btn_inc, btn_dec, btn_load;
  logic [3:0] Init_unitvalue, Init_dozenvalue;
  logic       set_time, editing, edit_digit;

  timer60_setter dut (
    .Clk             (Clk),
    .reset_n         (reset_n),
    .btn_mode        (btn_mode),
    .btn_inc         (btn_inc),
    .btn_dec         (btn_dec),
    .btn_load        (btn_load),
    .Init_unitvalue  (Init_unitvalue),
    .Init_dozenvalue (Init_dozenvalue),
    .set_time        (set_time),
    .editing         (editing),
    .edit_digit      (edit_digit)
  );

  always #5 Clk = ~Clk;

  int strb = 0;
  always @(posedge Clk) if (set_time === 1'b1) strb++;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [3:0] L = 4'b1000;
  localparam logic [3:0] M = 4'b0100;
  localparam logic [3:0] I = 4'b0010;
  localparam logic [3:0] D = 4'b0001;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] u;
    logic [3:0] d;
    logic       ed;
    logic       dg;
    int         st;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] b);
    {btn_load, btn_mode, btn_inc, btn_dec} = b;
  endtask

  task automatic apply(input string nm, input logic [3:0] b,
                       input logic [3:0] u, input logic [3:0] d,
                       input logic ed, input logic dg, input int st);
    int s0;
    s0 = strb;
    @(negedge Clk);
    drive(b);
    @(negedge Clk);
    drive(4'b0000);
    repeat (5) @(negedge Clk);
    chk({nm, " unit"}, 32'(Init_unitvalue), 32'(u));
    chk({nm, " dozen"}, 32'(Init_dozenvalue), 32'(d));
    chk({nm, " editing"}, 32'(editing), 32'(ed));
    chk({nm, " edit_digit"}, 32'(edit_digit), 32'(dg));
    chk({nm, " set_time"}, 32'(set_time), 32'd0);
    chk({nm, " strobes"}, 32'(strb - s0), 32'(st));
  endtask

  initial begin
    int s0;
    vecs.push_back('{M,     4'd0, 4'd0, 1'b1, 1'b0, 0});
    vecs.push_back('{I,     4'd1, 4'd0, 1'b1, 1'b0, 0});
    vecs.push_back('{I,     4'd2, 4'd0, 1'b1, 1'b0, 0});
    vecs.push_back('{I,     4'd3, 4'd0, 1'b1, 1'b0, 0});
    vecs.push_back('{M,     4'd3, 4'd0, 1'b1, 1'b1, 0});
    vecs.push_back('{I,     4'd3, 4'd1, 1'b1, 1'b1, 0});
    vecs.push_back('{I,     4'd3, 4'd2, 1'b1, 1'b1, 0});
    vecs.push_back('{L,     4'd3, 4'd2, 1'b0, 1'b0, 1});
    vecs.push_back('{I,     4'd3, 4'd2, 1'b0, 1'b0, 0});
    vecs.push_back('{D,     4'd3, 4'd2, 1'b0, 1'b0, 0});
    vecs.push_back('{L,     4'd3, 4'd2, 1'b0, 1'b0, 1});
    vecs.push_back('{M,     4'd3, 4'd2, 1'b1, 1'b0, 0});
    vecs.push_back('{I | D, 4'd3, 4'd2, 1'b1, 1'b0, 0});
    vecs.push_back('{D,     4'd2, 4'd2, 1'b1, 1'b0, 0});
    vecs.push_back('{D,     4'd1, 4'd2, 1'b1, 1'b0, 0});
    vecs.push_back('{D,     4'd0, 4'd2, 1'b1, 1'b0, 0});
    vecs.push_back('{D,     4'd9, 4'd2, 1'b1, 1'b0, 0});
    vecs.push_back('{I,     4'd0, 4'd2, 1'b1, 1'b0, 0});
    vecs.push_back('{D,     4'd9, 4'd2, 1'b1, 1'b0, 0});
    vecs.push_back('{M,     4'd9, 4'd2, 1'b1, 1'b1, 0});
    vecs.push_back('{D,     4'd9, 4'd1, 1'b1, 1'b1, 0});
    vecs.push_back('{D,     4'd9, 4'd0, 1'b1, 1'b1, 0});
    vecs.push_back('{D,     4'd9, 4'd5, 1'b1, 1'b1, 0});
    vecs.push_back('{I,     4'd9, 4'd0, 1'b1, 1'b1, 0});
    vecs.push_back('{I | D, 4'd9, 4'd0, 1'b1, 1'b1, 0});
    vecs.push_back('{D,     4'd9, 4'd5, 1'b1, 1'b1, 0});
    vecs.push_back('{M | I, 4'd9, 4'd5, 1'b0, 1'b0, 0});
    vecs.push_back('{M,     4'd9, 4'd5, 1'b1, 1'b0, 0});
    vecs.push_back('{M | L, 4'd9, 4'd5, 1'b0, 1'b0, 1});
    vecs.push_back('{L | I, 4'd9, 4'd5, 1'b0, 1'b0, 1});
    vecs.push_back('{M,     4'd9, 4'd5, 1'b1, 1'b0, 0});

    reset_n = 1'b0;
    drive(4'b0000);
    #2;
    chk("reset unit", 32'(Init_unitvalue), 32'd0);
    chk("reset dozen", 32'(Init_dozenvalue), 32'd0);
    chk("reset set_time", 32'(set_time), 32'd0);
    chk("reset editing", 32'(editing), 32'd0);
    chk("reset edit_digit", 32'(edit_digit), 32'd0);
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].btn, vecs[i].u,
            vecs[i].d, vecs[i].ed, vecs[i].dg, vecs[i].st);

    // latency k+3 and one pulse for a held button (EDIT_UNIT, unit 9)
    @(negedge Clk);
    btn_inc = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(posedge Clk);
    #1 chk("lat k+2 unit", 32'(Init_unitvalue), 32'd9);
    @(posedge Clk);
    #1 chk("lat k+3 unit", 32'(Init_unitvalue), 32'd0);
    repeat (10) @(posedge Clk);
    #1 chk("held unit", 32'(Init_unitvalue), 32'd0);
    @(negedge Clk);
    btn_inc = 1'b0;
    repeat (4) @(negedge Clk);

    for (int i = 1; i <= 5; i++)
      apply($sformatf("pre%0d", i), I, 4'(i), 4'd5, 1'b1, 1'b0, 0);
    apply("to_dozen", M, 4'd5, 4'd5, 1'b1, 1'b1, 0);
    apply("dozen4", D, 4'd5, 4'd4, 1'b1, 1'b1, 0);

    // asynchronous reset mid-edit, checked before any clock edge
    s0 = strb;
    @(negedge Clk);
    reset_n = 1'b0;
    #2;
    chk("areset unit", 32'(Init_unitvalue), 32'd0);
    chk("areset dozen", 32'(Init_dozenvalue), 32'd0);
    chk("areset editing", 32'(editing), 32'd0);
    chk("areset edit_digit", 32'(edit_digit), 32'd0);
    chk("areset set_time", 32'(set_time), 32'd0);
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("areset strobes", 32'(strb - s0), 32'd0);
    chk("post editing", 32'(editing), 32'd0);
    apply("post inc", I, 4'd0, 4'd0, 1'b0, 1'b0, 0);
    apply("post mode", M, 4'd0, 4'd0, 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
